// File: rtl/exercise_1a_if.sv
// Signal bundle for the exercise_1a Boolean function unit.
// Carries the A..D inputs and the f_comb/f/idx/err results.
interface exercise_1a_if;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       f_comb;
  logic       f;
  logic [3:0] idx;
  logic       err;

  modport master (
    output A,
    output B,
    output C,
    output D,
    input  f_comb,
    input  f,
    input  idx,
    input  err
  );

  modport slave (
    input  A,
    input  B,
    input  C,
    input  D,
    output f_comb,
    output f,
    output idx,
    output err
  );
endinterface

// File: rtl/exercise_1a.sv
// Registered 4-input Boolean unit: f = B'D' + B'C' + A'C'D (m 0,1,2,5,8,9,10).
// Ports: clk, rst_n (async low), bus (slave: A..D in; f_comb, f, idx, err out).
module exercise_1a #(
  parameter logic [15:0] TRUTH   = 16'h0727,
  parameter bit          USE_SOP = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  exercise_1a_if.slave  bus
);

  logic       w_na;
  logic       w_nb;
  logic       w_nc;
  logic       w_nd;
  logic       w_t0;
  logic       w_t1;
  logic       w_t2;
  logic       w_sop;
  logic       w_lut;
  logic       w_f_comb;
  logic       w_mis;
  logic [3:0] w_idx;

  logic       r_f;
  logic [3:0] r_idx;
  logic       r_err;

  assign w_na = ~bus.A;
  assign w_nb = ~bus.B;
  assign w_nc = ~bus.C;
  assign w_nd = ~bus.D;

  assign w_t0 = w_nb & w_nd;
  assign w_t1 = w_nb & w_nc;
  assign w_t2 = w_na & w_nc & bus.D;

  assign w_sop = w_t0 | w_t1 | w_t2;

  assign w_idx = {bus.A, bus.B, bus.C, bus.D};
  assign w_lut = TRUTH[w_idx];

  assign w_f_comb = USE_SOP ? w_sop : w_lut;

  // Gate network and table must agree on every sampled minterm.
  assign w_mis = w_sop ^ w_lut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f   <= 1'b0;
      r_idx <= 4'h0;
      r_err <= 1'b0;
    end else begin
      r_f   <= w_f_comb;
      r_idx <= w_idx;
      if (w_mis) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.f_comb = w_f_comb;
  assign bus.f      = r_f;
  assign bus.idx    = r_idx;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_exercise_1a.sv
// Directed bench for exercise_1a: default, bad-table and LUT-mode instances.
// All instances share clk, rst_n and the A..D stimulus.
module tb_exercise_1a;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exercise_1a_if b0 ();
  exercise_1a_if b1 ();
  exercise_1a_if b2 ();

  exercise_1a u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  exercise_1a #(
    .TRUTH   (16'h0726),
    .USE_SOP (1'b1)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  exercise_1a #(
    .TRUTH   (16'h8000),
    .USE_SOP (1'b0)
  ) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written table, index = {A,B,C,D}.
  logic exp_tbl [16] = '{
    1'b1, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b1, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0
  };

  task automatic set_in(input logic [3:0] v);
    b0.A = v[3]; b0.B = v[2]; b0.C = v[1]; b0.D = v[0];
    b1.A = v[3]; b1.B = v[2]; b1.C = v[1]; b1.D = v[0];
    b2.A = v[3]; b2.B = v[2]; b2.C = v[1]; b2.D = v[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(4'h0);
    step();
    step();
    total++;
    if (b0.f !== 1'b0) begin
      bad++;
      $display("FAIL rst_f got=%b want=0", b0.f);
    end
    total++;
    if (b0.idx !== 4'h0) begin
      bad++;
      $display("FAIL rst_idx got=%h want=0", b0.idx);
    end
    total++;
    if (b0.err !== 1'b0) begin
      bad++;
      $display("FAIL rst_err got=%b want=0", b0.err);
    end
    total++;
    if (b0.f_comb !== 1'b1) begin
      bad++;
      $display("FAIL rst_fcomb got=%b want=1", b0.f_comb);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (b0.f !== 1'b1) begin
      bad++;
      $display("FAIL rel_f got=%b want=1", b0.f);
    end
    total++;
    if (b0.idx !== 4'h0) begin
      bad++;
      $display("FAIL rel_idx got=%h want=0", b0.idx);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      set_in(v);
      #1;
      total++;
      if (b0.f_comb !== exp_tbl[i]) begin
        bad++;
        $display("FAIL sweep_fcomb[%0d] got=%b want=%b",
                 i, b0.f_comb, exp_tbl[i]);
      end
      total++;
      if (b2.f_comb !== (i == 15)) begin
        bad++;
        $display("FAIL lut_fcomb[%0d] got=%b want=%b",
                 i, b2.f_comb, (i == 15));
      end
      step();
      total++;
      if (b0.f !== exp_tbl[i]) begin
        bad++;
        $display("FAIL sweep_f[%0d] got=%b want=%b",
                 i, b0.f, exp_tbl[i]);
      end
      total++;
      if (b0.idx !== v) begin
        bad++;
        $display("FAIL sweep_idx[%0d] got=%h want=%h",
                 i, b0.idx, v);
      end
      total++;
      if (b0.err !== 1'b0) begin
        bad++;
        $display("FAIL sweep_err[%0d] got=%b want=0", i, b0.err);
      end
    end
  endtask

  task automatic test_boundary();
    logic [3:0] vecs [4] = '{4'h5, 4'h3, 4'hA, 4'hF};
    logic       want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      set_in(vecs[k]);
      step();
      total++;
      if (b0.f !== want[k] || b0.idx !== vecs[k]) begin
        bad++;
        $display("FAIL bound_%h got f=%b idx=%h want f=%b",
                 vecs[k], b0.f, b0.idx, want[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(4'h9);
    step();
    total++;
    if (b0.f !== 1'b1 || b0.idx !== 4'h9) begin
      bad++;
      $display("FAIL pre_async got f=%b idx=%h want f=1 idx=9",
               b0.f, b0.idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (b0.f !== 1'b0 || b0.idx !== 4'h0 || b0.err !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got f=%b idx=%h err=%b want 0/0/0",
               b0.f, b0.idx, b0.err);
    end
    total++;
    if (b0.f_comb !== 1'b1) begin
      bad++;
      $display("FAIL async_fcomb got=%b want=1", b0.f_comb);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_self_check();
    rst_n = 1'b0;
    set_in(4'h0);
    step();
    total++;
    if (b1.err !== 1'b0) begin
      bad++;
      $display("FAIL sc_rst_err got=%b want=0", b1.err);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (b1.err !== 1'b1) begin
      bad++;
      $display("FAIL sc_set_err got=%b want=1", b1.err);
    end
    total++;
    if (b0.err !== 1'b0) begin
      bad++;
      $display("FAIL sc_good_err got=%b want=0", b0.err);
    end
    set_in(4'h5);
    step();
    set_in(4'h8);
    step();
    total++;
    if (b1.err !== 1'b1) begin
      bad++;
      $display("FAIL sc_sticky got=%b want=1", b1.err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (b1.err !== 1'b0) begin
      bad++;
      $display("FAIL sc_clear got=%b want=0", b1.err);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_lut();
    rst_n = 1'b0;
    set_in(4'h3);
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (b2.err !== 1'b0 || b2.f !== 1'b0) begin
      bad++;
      $display("FAIL lut_3 got err=%b f=%b want 0/0", b2.err, b2.f);
    end
    set_in(4'hF);
    #1;
    total++;
    if (b2.f_comb !== 1'b1) begin
      bad++;
      $display("FAIL lut_fcomb_F got=%b want=1", b2.f_comb);
    end
    step();
    total++;
    if (b2.f !== 1'b1 || b2.err !== 1'b1) begin
      bad++;
      $display("FAIL lut_F got f=%b err=%b want 1/1", b2.f, b2.err);
    end
    rst_n = 1'b0;
    set_in(4'h0);
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (b2.f !== 1'b0 || b2.err !== 1'b1) begin
      bad++;
      $display("FAIL lut_0 got f=%b err=%b want 0/1", b2.f, b2.err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    set_in(4'h0);
    test_reset();
    test_sweep();
    test_boundary();
    test_async_reset();
    test_self_check();
    test_lut();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
